// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel pushbutton conditioner. Each channel is fully independent and
// provides a two-flop input synchroniser, a counter-based debounce filter,
// one-cycle press/release pulses, a long-press level and an optional
// auto-repeat pulse train.
//
// Parameters:
//   els_p        number of channels
//   width_p      debounce counter width; a new level must be seen on
//                2^width_p consecutive synchronised samples to be accepted
//   hold_width_p hold/repeat counter width; long-press threshold and repeat
//                period are both 2^hold_width_p cycles
//
// Ports:
//   clk_i        system clock
//   reset_n_i    asynchronous active-low reset, clears every flop
//   button_i     raw asynchronous pad inputs, active-high
//   repeat_en_i  global auto-repeat enable (synchronous to clk_i)
//   debounce_o   debounced level
//   rise_o       one-cycle press pulse, aligned with debounce_o rising
//   fall_o       one-cycle release pulse, aligned with debounce_o falling
//   hold_o       long-press level
//   repeat_o     one-cycle auto-repeat pulse
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int els_p        = 4,
  parameter int width_p      = 16,
  parameter int hold_width_p = 24
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [els_p-1:0] button_i,
  input  logic             repeat_en_i,
  output logic [els_p-1:0] debounce_o,
  output logic [els_p-1:0] rise_o,
  output logic [els_p-1:0] fall_o,
  output logic [els_p-1:0] hold_o,
  output logic [els_p-1:0] repeat_o
);

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_ch
      logic                    sync1_reg;
      logic                    sync2_reg;
      logic                    db_reg;
      logic                    db_next;
      logic [width_p-1:0]      cnt_reg;
      logic [width_p-1:0]      cnt_next;
      logic [hold_width_p-1:0] hcnt_reg;
      logic [hold_width_p-1:0] hcnt_next;
      logic                    hold_reg;
      logic                    hold_next;
      logic                    rise_reg;
      logic                    fall_reg;
      logic                    repeat_reg;
      logic                    repeat_next;

      // Debounce filter: any sample matching the accepted level restarts the
      // count, so only an unbroken run of 2^width_p differing samples flips it.
      always_comb begin
        db_next  = db_reg;
        cnt_next = '0;
        if (sync2_reg != db_reg) begin
          if (cnt_reg == '1) begin
            db_next = sync2_reg;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      // Hold/repeat counter. It is held at zero on the edge the press is
      // accepted and only advances once debounce_o is already high, so the
      // long-press window covers a full 2^hold_width_p cycles of debounced
      // high and repeats fall every 2^hold_width_p cycles after that.
      // Clearing on db_next drops hold_o on the same edge debounce_o falls.
      always_comb begin
        hcnt_next   = '0;
        hold_next   = 1'b0;
        repeat_next = 1'b0;
        if (db_next && db_reg) begin
          if (hcnt_reg == '1) begin
            hold_next   = 1'b1;
            // The edge that first raises hold_o never repeats; the enable
            // gates only the pulse, never the counter, so phase is kept.
            repeat_next = hold_reg & repeat_en_i;
          end else begin
            hcnt_next = hcnt_reg + 1'b1;
            hold_next = hold_reg;
          end
        end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          db_reg     <= 1'b0;
          cnt_reg    <= '0;
          hcnt_reg   <= '0;
          hold_reg   <= 1'b0;
          rise_reg   <= 1'b0;
          fall_reg   <= 1'b0;
          repeat_reg <= 1'b0;
        end else begin
          sync1_reg  <= button_i[gi];
          sync2_reg  <= sync1_reg;
          db_reg     <= db_next;
          cnt_reg    <= cnt_next;
          hcnt_reg   <= hcnt_next;
          hold_reg   <= hold_next;
          rise_reg   <= ~db_reg & db_next;
          fall_reg   <= db_reg & ~db_next;
          repeat_reg <= repeat_next;
        end
      end

      assign debounce_o[gi] = db_reg;
      assign rise_o[gi]     = rise_reg;
      assign fall_o[gi]     = fall_reg;
      assign hold_o[gi]     = hold_reg;
      assign repeat_o[gi]   = repeat_reg;
    end
  endgenerate

endmodule
